// File: rtl/falling_object_pool.sv
// falling_object_pool: N independent falling obstacles sharing one block.
// Each slot runs IDLE -> WAIT -> FALL, draws its spawn column and respawn
// delay from a private 16-bit LFSR, and falls by 'speed' pixels per frame.
// A registered priority hit-test reports the lowest-index visible slot under
// the current pixel together with the in-object offsets.
// Optional feature: define FALLING_POOL_SCORE_EN to count objects that leave
// the bottom of the screen on passedCount (tied to zero otherwise).
module falling_object_pool #(
   parameter int N_OBJECTS       = 4,
   parameter int OBJ_W           = 32,
   parameter int OBJ_H           = 32,
   parameter int SCREEN_H        = 480,
   parameter int MIN_X           = 48,
   parameter int MAX_X           = 592,
   parameter int MIN_WAIT        = 5,
   parameter int WAIT_RANGE_BITS = 4,
   parameter int STAGGER         = 3
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [10:0]          pixelX,
   input  logic [10:0]          pixelY,
   input  logic                 startOfFrame,
   input  logic                 oneTensSec,
   input  logic                 startofLevel,
   input  logic                 endLevel,
   input  logic                 enable,
   input  logic [3:0]           seedindex,
   input  logic [3:0]           speed,
   output logic                 drawingRequest,
   output logic [2:0]           hitIndex,
   output logic [10:0]          offsetX,
   output logic [10:0]          offsetY,
   output logic [N_OBJECTS-1:0] visibleMask,
   output logic [15:0]          passedCount
);

   localparam int X_SPAN  = MAX_X - MIN_X;
   localparam int CNT_MAX = MIN_WAIT + (N_OBJECTS - 1) * STAGGER + (1 << WAIT_RANGE_BITS) - 1;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_FALL
   } slot_state_t;

   slot_state_t      r_state    [N_OBJECTS];
   slot_state_t      w_state_nx [N_OBJECTS];
   logic [10:0]      r_x        [N_OBJECTS];
   logic [10:0]      w_x_nx     [N_OBJECTS];
   logic [10:0]      r_y        [N_OBJECTS];
   logic [10:0]      w_y_nx     [N_OBJECTS];
   logic [CNT_W-1:0] r_cnt      [N_OBJECTS];
   logic [CNT_W-1:0] w_cnt_nx   [N_OBJECTS];
   logic [15:0]      r_lfsr     [N_OBJECTS];
   logic [15:0]      w_lfsr_nx  [N_OBJECTS];
   logic [15:0]      w_seed     [N_OBJECTS];
   logic             r_reseed;
   logic [11:0]      w_ysum;
   logic             w_fb;
`ifdef FALLING_POOL_SCORE_EN
   logic [N_OBJECTS-1:0] w_exit;
`endif

   logic             w_hit;
   logic [2:0]       w_idx;
   logic [10:0]      w_ox;
   logic [10:0]      w_oy;

   // Map a 10-bit random value onto 0..X_SPAN: one wrap, then clamp.
   function automatic logic [10:0] fold_x(input logic [9:0] v);
      logic [11:0] t;
      t = {2'b00, v};
      if (t > 12'(X_SPAN)) t = t - 12'(X_SPAN + 1);
      if (t > 12'(X_SPAN)) t = 12'(X_SPAN);
      return 11'(t) + 11'(MIN_X);
   endfunction

   // Per-slot LFSR seeds derived from seedindex; zero would lock the LFSR.
   always_comb begin
      for (int unsigned i = 0; i < N_OBJECTS; i++) begin
         w_seed[i] = {seedindex, 12'hACE} ^ 16'(i * 32'h1F35);
         if (w_seed[i] == '0) w_seed[i] = 16'h0001;
      end
   end

   // Slot next-state: level pulses first, then WAIT countdown / FALL motion.
   always_comb begin
      w_ysum = '0;
      w_fb   = 1'b0;
`ifdef FALLING_POOL_SCORE_EN
      w_exit = '0;
`endif
      for (int unsigned i = 0; i < N_OBJECTS; i++) begin
         w_state_nx[i] = r_state[i];
         w_x_nx[i]     = r_x[i];
         w_y_nx[i]     = r_y[i];
         w_cnt_nx[i]   = r_cnt[i];
         w_fb          = r_lfsr[i][15] ^ r_lfsr[i][13] ^ r_lfsr[i][12] ^ r_lfsr[i][10];
         w_lfsr_nx[i]  = startofLevel ? w_seed[i] : {r_lfsr[i][14:0], w_fb};
         w_ysum        = {1'b0, r_y[i]} + {8'b0, speed};
         if (endLevel) begin
            w_state_nx[i] = S_IDLE;
            w_x_nx[i]     = 11'(MIN_X);
            w_y_nx[i]     = '0;
            w_cnt_nx[i]   = '0;
         end else if (startofLevel) begin
            w_state_nx[i] = S_WAIT;
            w_cnt_nx[i]   = CNT_W'(MIN_WAIT + i * STAGGER)
                          + CNT_W'(w_seed[i][WAIT_RANGE_BITS-1:0]);
         end else if (enable) begin
            case (r_state[i])
               S_WAIT: begin
                  if (oneTensSec) begin
                     if (r_cnt[i] <= CNT_W'(1)) begin
                        w_state_nx[i] = S_FALL;
                        w_y_nx[i]     = '0;
                        w_x_nx[i]     = fold_x(r_lfsr[i][9:0]);
                        w_cnt_nx[i]   = '0;
                     end else begin
                        w_cnt_nx[i]   = r_cnt[i] - CNT_W'(1);
                     end
                  end
               end
               S_FALL: begin
                  if (startOfFrame) begin
                     if (w_ysum >= 12'(SCREEN_H)) begin
                        w_state_nx[i] = S_WAIT;
                        w_cnt_nx[i]   = CNT_W'(MIN_WAIT)
                                      + CNT_W'(r_lfsr[i][WAIT_RANGE_BITS-1:0]);
`ifdef FALLING_POOL_SCORE_EN
                        w_exit[i]     = 1'b1;
`endif
                     end else begin
                        w_y_nx[i]     = w_ysum[10:0];
                     end
                  end
               end
               default: ;
            endcase
         end
      end
   end

   // Slot registers. The LFSR seed is taken on the first clock after reset
   // so that reset stays a constant load; slots are IDLE until the next
   // startofLevel reseeds anyway, so the one-clock shift is not observable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_reseed <= 1'b1;
         for (int unsigned i = 0; i < N_OBJECTS; i++) begin
            r_state[i] <= S_IDLE;
            r_x[i]     <= 11'(MIN_X);
            r_y[i]     <= '0;
            r_cnt[i]   <= '0;
            r_lfsr[i]  <= '0;
         end
      end else begin
         r_reseed <= 1'b0;
         for (int unsigned i = 0; i < N_OBJECTS; i++) begin
            r_state[i] <= w_state_nx[i];
            r_x[i]     <= w_x_nx[i];
            r_y[i]     <= w_y_nx[i];
            r_cnt[i]   <= w_cnt_nx[i];
            r_lfsr[i]  <= r_reseed ? w_seed[i] : w_lfsr_nx[i];
         end
      end
   end

   // Priority hit-test of the current pixel; the first (lowest) slot wins.
   always_comb begin
      w_hit = 1'b0;
      w_idx = '0;
      w_ox  = '0;
      w_oy  = '0;
      for (int unsigned i = 0; i < N_OBJECTS; i++) begin
         if (!w_hit && r_state[i] == S_FALL
             && {1'b0, pixelX} >= {1'b0, r_x[i]}
             && {1'b0, pixelX} <  {1'b0, r_x[i]} + 12'(OBJ_W)
             && {1'b0, pixelY} >= {1'b0, r_y[i]}
             && {1'b0, pixelY} <  {1'b0, r_y[i]} + 12'(OBJ_H)) begin
            w_hit = 1'b1;
            w_idx = 3'(i);
            w_ox  = pixelX - r_x[i];
            w_oy  = pixelY - r_y[i];
         end
      end
   end

   // Register the hit result for the draw stage.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         drawingRequest <= 1'b0;
         hitIndex       <= '0;
         offsetX        <= '0;
         offsetY        <= '0;
      end else begin
         drawingRequest <= w_hit;
         hitIndex       <= w_idx;
         offsetX        <= w_ox;
         offsetY        <= w_oy;
      end
   end

   // A slot is visible exactly while it is falling.
   always_comb begin
      for (int unsigned i = 0; i < N_OBJECTS; i++) begin
         visibleMask[i] = (r_state[i] == S_FALL);
      end
   end

`ifdef FALLING_POOL_SCORE_EN
   logic [15:0] r_passed;
   logic [3:0]  w_exit_cnt;
   logic [16:0] w_passed_sum;

   // Count slots leaving the screen this clock.
   always_comb begin
      w_exit_cnt = '0;
      for (int unsigned i = 0; i < N_OBJECTS; i++) begin
         w_exit_cnt = w_exit_cnt + 4'(w_exit[i]);
      end
      w_passed_sum = {1'b0, r_passed} + 17'(w_exit_cnt);
   end

   // Saturating exit counter, cleared at level start.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_passed <= '0;
      end else if (startofLevel) begin
         r_passed <= '0;
      end else if (w_passed_sum > 17'h0FFFF) begin
         r_passed <= 16'hFFFF;
      end else begin
         r_passed <= w_passed_sum[15:0];
      end
   end

   assign passedCount = r_passed;
`else
   assign passedCount = '0;
`endif

endmodule

// File: tb/tb_falling_object_pool.sv
// Scoreboard bench for falling_object_pool: a behavioural slot model predicts
// hit results (queued when the pixel is driven, compared one clock later),
// visibleMask and passedCount.
module tb_falling_object_pool;

   localparam int N        = 4;
   localparam int OBJ_W    = 32;
   localparam int OBJ_H    = 32;
   localparam int SCREEN_H = 480;
   localparam int MIN_X    = 48;
   localparam int MAX_X    = 592;
   localparam int MIN_WAIT = 5;
   localparam int STAGGER  = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic [10:0]   pixelX, pixelY;
   logic          startOfFrame, oneTensSec, startofLevel, endLevel, enable;
   logic [3:0]    seedindex, speed;
   logic          drawingRequest;
   logic [2:0]    hitIndex;
   logic [10:0]   offsetX, offsetY;
   logic [N-1:0]  visibleMask;
   logic [15:0]   passedCount;

   always #5 clk = ~clk;

   falling_object_pool #(
      .N_OBJECTS(N), .OBJ_W(OBJ_W), .OBJ_H(OBJ_H), .SCREEN_H(SCREEN_H),
      .MIN_X(MIN_X), .MAX_X(MAX_X), .MIN_WAIT(MIN_WAIT),
      .WAIT_RANGE_BITS(4), .STAGGER(STAGGER)
   ) dut (
      .clk(clk), .reset(reset), .pixelX(pixelX), .pixelY(pixelY),
      .startOfFrame(startOfFrame), .oneTensSec(oneTensSec),
      .startofLevel(startofLevel), .endLevel(endLevel), .enable(enable),
      .seedindex(seedindex), .speed(speed),
      .drawingRequest(drawingRequest), .hitIndex(hitIndex),
      .offsetX(offsetX), .offsetY(offsetY),
      .visibleMask(visibleMask), .passedCount(passedCount)
   );

   typedef struct packed {
      logic        dr;
      logic [2:0]  idx;
      logic [10:0] ox;
      logic [10:0] oy;
   } hit_t;

   hit_t        sb_q[$];
   int          errors = 0;
   int          checks = 0;
   int          m_st[N];      // 0 idle, 1 wait, 2 fall
   int          m_x[N], m_y[N], m_cnt[N];
   logic [15:0] m_lfsr[N];
   int          m_passed, m_spawns;
   logic        last_dr;

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] seed_of(input int i);
      logic [15:0] s;
      s = {seedindex, 12'hACE} ^ 16'(i * 32'h1F35);
      if (s == 16'h0000) s = 16'h0001;
      return s;
   endfunction

   function automatic int fold(input int v);
      int r;
      r = MAX_X - MIN_X;
      if (v <= r) return v;
      if (v - (r + 1) <= r) return v - (r + 1);
      return r;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_st[i] = 0; m_x[i] = MIN_X; m_y[i] = 0; m_cnt[i] = 0;
         m_lfsr[i] = seed_of(i);
      end
      m_passed = 0;
   endtask

   task automatic model_step();
      int exits;
      logic [15:0] l, s;
      exits = 0;
      for (int i = 0; i < N; i++) begin
         l = m_lfsr[i];
         s = seed_of(i);
         if (endLevel) begin
            m_st[i] = 0; m_x[i] = MIN_X; m_y[i] = 0; m_cnt[i] = 0;
         end else if (startofLevel) begin
            m_st[i] = 1;
            m_cnt[i] = MIN_WAIT + i * STAGGER + int'(s[3:0]);
         end else if (enable) begin
            if (m_st[i] == 1 && oneTensSec) begin
               if (m_cnt[i] <= 1) begin
                  m_st[i] = 2; m_y[i] = 0; m_cnt[i] = 0;
                  m_x[i] = MIN_X + fold(int'(l[9:0]));
                  m_spawns++;
               end else begin
                  m_cnt[i] = m_cnt[i] - 1;
               end
            end else if (m_st[i] == 2 && startOfFrame) begin
               if (m_y[i] + int'(speed) >= SCREEN_H) begin
                  m_st[i] = 1;
                  m_cnt[i] = MIN_WAIT + int'(l[3:0]);
                  exits++;
               end else begin
                  m_y[i] = m_y[i] + int'(speed);
               end
            end
         end
         m_lfsr[i] = startofLevel ? s : {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      end
      if (startofLevel) m_passed = 0;
      else begin
         m_passed = m_passed + exits;
         if (m_passed > 65535) m_passed = 65535;
      end
   endtask

   function automatic hit_t model_hit(input int px, input int py);
      hit_t h;
      h = '0;
      for (int i = 0; i < N; i++) begin
         if (m_st[i] == 2 && px >= m_x[i] && px < m_x[i] + OBJ_W
             && py >= m_y[i] && py < m_y[i] + OBJ_H) begin
            h.dr  = 1'b1;
            h.idx = 3'(i);
            h.ox  = 11'(px - m_x[i]);
            h.oy  = 11'(py - m_y[i]);
            return h;
         end
      end
      return h;
   endfunction

   // Aim the pixel at overlaps, corners and just-outside edges of visible slots.
   task automatic pick_pixel();
      int vis[$];
      int px, py, t, dx, dy;
      for (int i = 0; i < N; i++) if (m_st[i] == 2) vis.push_back(i);
      if (vis.size() == 0) begin
         pixelX = 11'($urandom_range(0, 700));
         pixelY = 11'($urandom_range(0, 520));
         return;
      end
      if ($urandom_range(0, 1) == 1) begin
         for (int i = 0; i < N; i++) begin
            for (int j = i + 1; j < N; j++) begin
               dx = m_x[i] - m_x[j]; if (dx < 0) dx = -dx;
               dy = m_y[i] - m_y[j]; if (dy < 0) dy = -dy;
               if (m_st[i] == 2 && m_st[j] == 2 && dx < OBJ_W && dy < OBJ_H) begin
                  pixelX = 11'((m_x[i] > m_x[j]) ? m_x[i] : m_x[j]);
                  pixelY = 11'((m_y[i] > m_y[j]) ? m_y[i] : m_y[j]);
                  return;
               end
            end
         end
      end
      t = vis[$urandom_range(0, vis.size() - 1)];
      case ($urandom_range(0, 5))
         0: begin px = m_x[t];             py = m_y[t];             end
         1: begin px = m_x[t] + OBJ_W - 1; py = m_y[t] + OBJ_H - 1; end
         2: begin px = m_x[t] + OBJ_W;     py = m_y[t] + int'($urandom_range(0, OBJ_H - 1)); end
         3: begin px = m_x[t] + int'($urandom_range(0, OBJ_W - 1)); py = m_y[t] + OBJ_H; end
         4: begin px = m_x[t] - 1;         py = m_y[t];             end
         default: begin
            px = m_x[t] + int'($urandom_range(0, OBJ_W - 1));
            py = m_y[t] + int'($urandom_range(0, OBJ_H - 1));
         end
      endcase
      pixelX = 11'((px < 0) ? 0 : px);
      pixelY = 11'((py < 0) ? 0 : py);
   endtask

   task automatic check_side_outputs();
      logic [N-1:0] mm;
      for (int i = 0; i < N; i++) mm[i] = (m_st[i] == 2);
      check_val("visibleMask", 32'(visibleMask), 32'(mm));
`ifdef FALLING_POOL_SCORE_EN
      check_val("passedCount", 32'(passedCount), 32'(m_passed));
`else
      check_val("passedCount", 32'(passedCount), 32'(0));
`endif
   endtask

   // One clock: drive pixel, queue the prediction, compare after the edge.
   task automatic cycle();
      hit_t e;
      pick_pixel();
      sb_q.push_back(model_hit(int'(pixelX), int'(pixelY)));
      @(posedge clk);
      if (reset) model_reset(); else model_step();
      @(negedge clk);
      e = sb_q.pop_front();
      check_val("drawingRequest", 32'(drawingRequest), 32'(e.dr));
      check_val("hitIndex", 32'(hitIndex), 32'(e.idx));
      check_val("offsetX", 32'(offsetX), 32'(e.ox));
      check_val("offsetY", 32'(offsetY), 32'(e.oy));
      check_side_outputs();
      last_dr = e.dr;
      startOfFrame = 1'b0; oneTensSec = 1'b0; startofLevel = 1'b0; endLevel = 1'b0;
   endtask

   task automatic check_all_zero(input string tag);
      check_val({tag, "_dr"}, 32'(drawingRequest), 32'(0));
      check_val({tag, "_idx"}, 32'(hitIndex), 32'(0));
      check_val({tag, "_ox"}, 32'(offsetX), 32'(0));
      check_val({tag, "_oy"}, 32'(offsetY), 32'(0));
      check_val({tag, "_mask"}, 32'(visibleMask), 32'(0));
      check_val({tag, "_passed"}, 32'(passedCount), 32'(0));
   endtask

   initial begin
      int n, sp, base;
      reset = 1'b1; pixelX = '0; pixelY = '0;
      startOfFrame = 1'b0; oneTensSec = 1'b0; startofLevel = 1'b0; endLevel = 1'b0;
      enable = 1'b1; seedindex = 4'h0; speed = 4'd4;
      m_spawns = 0; last_dr = 1'b0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      model_reset();
      reset = 1'b0;

      // Level start, countdown ticks every 10 clocks until all slots fall.
      startofLevel = 1'b1; cycle();
      for (int k = 0; k < 400; k++) begin
         oneTensSec = (k % 10 == 9);
         cycle();
      end

      // Fall at speed 4 until slots leave the screen and respawn.
      for (int k = 0; k < 300; k++) begin
         startOfFrame = (k % 2 == 0);
         oneTensSec   = (k % 10 == 9);
         cycle();
      end

      // Frozen: 50 frames and ticks with enable low.
      enable = 1'b0;
      for (int k = 0; k < 50; k++) begin
         startOfFrame = 1'b1; oneTensSec = 1'b1; cycle();
      end
      enable = 1'b1;
      for (int k = 0; k < 20; k++) begin
         startOfFrame = 1'b1; oneTensSec = (k % 4 == 0); cycle();
      end

      // endLevel wins over startofLevel: every slot stays idle.
      endLevel = 1'b1; startofLevel = 1'b1; cycle();
      for (int k = 0; k < 100; k++) begin
         startOfFrame = 1'b1; oneTensSec = 1'b1; cycle();
      end

      // Stationary levels (speed 0) to build overlapping slots at Y=0.
      speed = 4'd0;
      for (int lv = 0; lv < 40; lv++) begin
         seedindex = 4'(lv);
         startofLevel = 1'b1; cycle();
         sp = int'($urandom_range(1, 3));
         for (int k = 0; k < 140; k++) begin
            oneTensSec = (k % sp == 0); startOfFrame = 1'b1; cycle();
         end
         endLevel = 1'b1; cycle();
      end

      // Fast respawning: at least 1000 spawns, each one hit-tested.
      seedindex = 4'h5; speed = 4'd15;
      startofLevel = 1'b1; cycle();
      base = m_spawns; n = 0;
      while (m_spawns - base < 1000 && n < 40000) begin
         startOfFrame = 1'b1; oneTensSec = 1'b1; cycle();
         n++;
      end

      // Asynchronous reset while a hit is being reported.
      n = 0;
      while (!last_dr && n < 2000) begin
         startOfFrame = 1'b1; oneTensSec = (n % 3 == 0); cycle();
         n++;
      end
      check_val("midreset_setup_dr", 32'(drawingRequest), 32'(1));
      #2 reset = 1'b1;
      #1 check_all_zero("midreset");
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      for (int k = 0; k < 50; k++) begin
         startOfFrame = 1'b1; oneTensSec = 1'b1; cycle();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
